reg_sequencer: RTL and testbench

//   Command sequencer that sits directly upstream of the 4-bit multi-function register and drives its control inputs.

---
 rtl/reg_sequencer_if.sv | 25 ++
 rtl/reg_sequencer.sv | 113 +++++++++++
 tb/tb_reg_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_sequencer_if.sv
// Command channel between a requester and reg_sequencer.
// A command (cmd_op/cmd_data/cmd_cnt) is transferred on a clock edge where
// cmd_valid and cmd_ready are both high.
//   master : requester side, drives valid/op/data/cnt, observes ready
//   slave  : sequencer side, observes valid/op/data/cnt, drives ready
interface reg_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/reg_sequencer.sv
// reg_sequencer: expands one accepted command into 0..2**CNT_W-1 single-cycle
// control strobes for a downstream multi-function register, then pulses done.
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   cmd          command channel (slave modport of reg_sequencer_if)
//   abort        ends a running command early; the strobe in that cycle is dropped
//   reg_q        register output, fed back so rotates can reinsert the outgoing bit
//   cl..sl       register control strobes, at most one high per cycle
//   ir, il       bit inserted on sr / sl
//   reg_in       register load data (latched command data)
//   done         one-cycle completion pulse
module reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_sequencer_if.slave   cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] reg_q,
  output logic             cl,
  output logic             ld,
  output logic             inc,
  output logic             dec,
  output logic             sr,
  output logic             sl,
  output logic             ir,
  output logic             il,
  output logic [WIDTH-1:0] reg_in,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_CLR, OP_LD, OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_ROR, OP_ROL
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] load_rem;
  logic             accept;
  logic             strobe_en;

  // Only the end bits of reg_q matter to the rotates.
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;

  assign accept = (state == IDLE) && cmd.cmd_valid;

  // CLR and LD are always a single strobe regardless of the count field.
  always_comb begin
    load_rem = cmd.cmd_cnt;
    if (cmd.cmd_op == OP_CLR || cmd.cmd_op == OP_LD)
      load_rem = CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd.cmd_valid) state_nxt = (load_rem == '0) ? DONE : RUN;
      RUN:  if (abort || rem == CNT_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and remaining-strobe counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_CLR;
      data_q <= '0;
      rem    <= '0;
    end else if (accept) begin
      op_q   <= op_t'(cmd.cmd_op);
      data_q <= cmd.cmd_data;
      rem    <= load_rem;
    end else if (state == RUN) begin
      rem    <= rem - CNT_W'(1);
    end
  end

  // Strobes come only from registered state; abort merely masks them.
  always_comb begin
    cl = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0; sr = 1'b0; sl = 1'b0;
    ir = 1'b0; il = 1'b0;
    strobe_en = (state == RUN) && !abort;
    if (strobe_en) begin
      case (op_q)
        OP_CLR: cl = 1'b1;
        OP_LD:  ld = 1'b1;
        OP_INC: inc = 1'b1;
        OP_DEC: dec = 1'b1;
        OP_SHR: begin sr = 1'b1; ir = data_q[0];       end
        OP_ROR: begin sr = 1'b1; ir = reg_q[0];        end
        OP_SHL: begin sl = 1'b1; il = data_q[0];       end
        OP_ROL: begin sl = 1'b1; il = reg_q[WIDTH-1];  end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_ready = (state == IDLE);
  assign done          = (state == DONE);
  assign reg_in        = data_q;

endmodule

// File: tb/tb_reg_sequencer.sv
module tb_reg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic [3:0] reg_q;
  logic       cl, ld, inc, dec, sr, sl, ir, il, done;
  logic [3:0] reg_in;
  logic [5:0] strb;

  int n_compared;
  int n_mismatched;

  reg_sequencer_if #(.WIDTH(4), .CNT_W(4)) cmd_bus ();

  reg_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_bus), .abort(abort), .reg_q(reg_q),
    .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .ir(ir), .il(il), .reg_in(reg_in), .done(done)
  );

  assign strb = {cl, ld, inc, dec, sr, sl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the 4-bit multi-function register being driven.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   reg_q <= 4'h0;
    else if (cl)  reg_q <= 4'h0;
    else if (ld)  reg_q <= reg_in;
    else if (inc) reg_q <= reg_q + 4'h1;
    else if (dec) reg_q <= reg_q - 4'h1;
    else if (sr)  reg_q <= {ir, reg_q[3:1]};
    else if (sl)  reg_q <= {reg_q[2:0], il};
  end

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  data;
    logic [3:0]  cnt;
    logic [5:0]  exp_strb;
    int          exp_pulses;
    logic [15:0] exp_bits;
    logic [3:0]  exp_q;
  } vec_t;

  vec_t vecs [0:17];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one command and watches it to completion. Returns the number of
  // correct strobe cycles, the cycle (relative to accept) in which done was
  // seen, the ir/il value of each strobe cycle (LSB first) and a count of
  // protocol violations. Returns in the done cycle, just after sampling.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] data,
                               input logic [3:0] cnt, input logic [5:0] exp_strb,
                               input int abort_at, output int pulses,
                               output int done_cyc, output logic [15:0] bits,
                               output int bad);
    pulses = 0; done_cyc = 0; bits = '0; bad = 0;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_data  = data;
    cmd_bus.cmd_cnt   = cnt;
    #1 if (!cmd_bus.cmd_ready) bad++;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      abort = (k == abort_at);
      #1;
      if (strb != 6'h00) begin
        if (strb == exp_strb && pulses < 16) begin
          bits[pulses] = ir | il;
          pulses++;
        end else begin
          bad++;
        end
      end
      if (ir && !sr) bad++;
      if (il && !sl) bad++;
      if (cmd_bus.cmd_ready) bad++;
      if (done) done_cyc = k;
      if (done_cyc == 0) @(negedge clk);
    end
    abort = 1'b0;
  endtask

  int          pulses, done_cyc, bad, seen;
  logic [15:0] bits;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    abort = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 3'd0;
    cmd_bus.cmd_data  = 4'h0;
    cmd_bus.cmd_cnt   = 4'h0;

    //                op    data   cnt    strobe pulses bits     q
    vecs[0]  = '{3'd1, 4'hA, 4'd0,  6'h10, 1,  16'h0000, 4'hA}; // LD A
    vecs[1]  = '{3'd1, 4'hE, 4'd0,  6'h10, 1,  16'h0000, 4'hE}; // LD E
    vecs[2]  = '{3'd2, 4'h0, 4'd3,  6'h08, 3,  16'h0000, 4'h1}; // INC x3 wraps
    vecs[3]  = '{3'd1, 4'h9, 4'd0,  6'h10, 1,  16'h0000, 4'h9}; // LD 9
    vecs[4]  = '{3'd6, 4'h0, 4'd2,  6'h02, 2,  16'h0001, 4'h6}; // ROR x2
    vecs[5]  = '{3'd5, 4'h1, 4'd4,  6'h01, 4,  16'h000F, 4'hF}; // SHL x4 fill 1
    vecs[6]  = '{3'd2, 4'h0, 4'd0,  6'h08, 0,  16'h0000, 4'hF}; // INC x0
    vecs[7]  = '{3'd0, 4'h0, 4'd0,  6'h20, 1,  16'h0000, 4'h0}; // CLR cnt 0
    vecs[8]  = '{3'd3, 4'h0, 4'd2,  6'h04, 2,  16'h0000, 4'hE}; // DEC x2 wraps
    vecs[9]  = '{3'd4, 4'h0, 4'd2,  6'h02, 2,  16'h0000, 4'h3}; // SHR x2 fill 0
    vecs[10] = '{3'd7, 4'h0, 4'd1,  6'h01, 1,  16'h0000, 4'h6}; // ROL x1
    vecs[11] = '{3'd4, 4'h1, 4'd1,  6'h02, 1,  16'h0001, 4'hB}; // SHR x1 fill 1
    vecs[12] = '{3'd1, 4'h5, 4'd7,  6'h10, 1,  16'h0000, 4'h5}; // LD, cnt ignored
    vecs[13] = '{3'd5, 4'h0, 4'd15, 6'h01, 15, 16'h0000, 4'h0}; // SHL x15
    vecs[14] = '{3'd7, 4'h0, 4'd0,  6'h01, 0,  16'h0000, 4'h0}; // ROL x0
    vecs[15] = '{3'd1, 4'h8, 4'd0,  6'h10, 1,  16'h0000, 4'h8}; // LD 8
    vecs[16] = '{3'd7, 4'h0, 4'd1,  6'h01, 1,  16'h0001, 4'h1}; // ROL msb wraps
    vecs[17] = '{3'd6, 4'h0, 4'd3,  6'h02, 3,  16'h0001, 4'h2}; // ROR x3

    // Reset state.
    #12;
    checkOutput("reset_strobes", strb, 6'h00);
    checkOutput("reset_irl", {ir, il}, 2'b00);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_reg_in", reg_in, 4'h0);
    checkOutput("reset_ready", cmd_bus.cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].exp_strb, 0,
                    pulses, done_cyc, bits, bad);
      checkOutput($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      checkOutput($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_pulses + 1);
      checkOutput($sformatf("v%0d_insert_bits", i), bits, vecs[i].exp_bits);
      checkOutput($sformatf("v%0d_violations", i), bad, 0);
      checkOutput($sformatf("v%0d_reg_q", i), reg_q, vecs[i].exp_q);
      checkOutput($sformatf("v%0d_reg_in", i), reg_in, vecs[i].data);
      @(negedge clk);
      #1;
      checkOutput($sformatf("v%0d_ready_after", i), cmd_bus.cmd_ready, 1'b1);
      checkOutput($sformatf("v%0d_done_single", i), done, 1'b0);
    end

    // Abort on the 4th strobe cycle of DEC x10 from 9.
    applyStimulus(3'd1, 4'h9, 4'd0, 6'h10, 0, pulses, done_cyc, bits, bad);
    applyStimulus(3'd3, 4'h0, 4'd10, 6'h04, 4, pulses, done_cyc, bits, bad);
    checkOutput("abort_pulses", pulses, 3);
    checkOutput("abort_done_cycle", done_cyc, 5);
    checkOutput("abort_violations", bad, 0);
    checkOutput("abort_reg_q", reg_q, 4'h6);
    @(negedge clk);
    #1 checkOutput("abort_ready_after", cmd_bus.cmd_ready, 1'b1);

    // Reset in the 2nd strobe cycle of SHR x5.
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 3'd4;
    cmd_bus.cmd_data  = 4'h0;
    cmd_bus.cmd_cnt   = 4'd5;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    #1 checkOutput("rst_cycle1_sr", strb, 6'h02);
    @(negedge clk);
    #1 checkOutput("rst_cycle2_sr", strb, 6'h02);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_strobes", strb, 6'h00);
    checkOutput("rst_async_done", done, 1'b0);
    checkOutput("rst_async_ready", cmd_bus.cmd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (strb != 6'h00 || done || !cmd_bus.cmd_ready) seen++;
    end
    checkOutput("rst_quiet_after", seen, 0);
    checkOutput("rst_reg_in", reg_in, 4'h0);

    // Recovery: a normal command works after reset.
    applyStimulus(3'd1, 4'h3, 4'd0, 6'h10, 0, pulses, done_cyc, bits, bad);
    checkOutput("recover_pulses", pulses, 1);
    checkOutput("recover_done_cycle", done_cyc, 2);
    checkOutput("recover_reg_q", reg_q, 4'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
